// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: FSM states, IF/ID payload and the canonical NOP.
package fetch_pkg;

  localparam int unsigned PC_W = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    LOOP     = 2'd1,
    REDIRECT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
    logic            from_loop;
  } ifid_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register with load/hold and bubble insertion.
module ifid_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,     // capture a real instruction
  input  logic            bubble,   // capture a NOP; wins over load
  input  logic [PC_W-1:0] pc,
  input  logic [31:0]     instr,
  input  logic            from_loop,
  output ifid_t           q
);

  // Register update: reset, bubble, load, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '{valid: 1'b0, pc: '0, instr: NOP_INSTR, from_loop: 1'b0};
    end else if (bubble) begin
      q <= '{valid: 1'b0, pc: pc, instr: NOP_INSTR, from_loop: 1'b0};
    end else if (load) begin
      q <= '{valid: 1'b1, pc: pc, instr: instr, from_loop: from_loop};
    end
  end

endmodule

// File: rtl/loop_fetch_stage.sv
// Fetch stage: owns the fetch PC, picks imem vs loop-buffer instructions,
// and inserts bubbles on loop exits and EX redirects.
module loop_fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC         = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR        = fetch_pkg::NOP_INSTR,
  parameter int unsigned REDIRECT_BUBBLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_if,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  input  logic [31:0] imem_instr,
  input  logic        loop_block,
  input  logic        loop_flush,
  input  logic [31:0] loop_new_pc,
  input  logic [31:0] loop_instr,
  output logic [31:0] curr_pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic        ifid_from_loop
);

  localparam int unsigned CW = (REDIRECT_BUBBLES == 0) ? 1 : $clog2(REDIRECT_BUBBLES + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'((REDIRECT_BUBBLES > 0) ? REDIRECT_BUBBLES - 1 : 0);
  localparam fetch_state_e AFTER_FLUSH = (REDIRECT_BUBBLES == 0) ? FETCH : REDIRECT;

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ld, bub, src_loop;
  logic [31:0]     instr_sel;
  ifid_t           ifid_q;

  // Next-state, next-PC, bubble counter and IF/ID controls.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    ld       = 1'b0;
    bub      = 1'b0;
    src_loop = 1'b0;
    if (loop_flush) begin
      // Loop exit beats everything, including a stall.
      pc_d    = loop_new_pc;
      bub     = 1'b1;
      cnt_d   = CNT_INIT;
      state_d = AFTER_FLUSH;
    end else if (ex_redirect && state_q != LOOP) begin
      // While looping the loop FSM owns exits, so EX redirects are dropped.
      pc_d    = ex_target;
      bub     = 1'b1;
      cnt_d   = CNT_INIT;
      state_d = (state_q == REDIRECT) ? AFTER_FLUSH : FETCH;
    end else if (stall_if) begin
      // Hold everything; only a loop entry may still be recorded.
      if (state_q == FETCH && loop_block) state_d = LOOP;
    end else begin
      unique case (state_q)
        FETCH: begin
          ld = 1'b1;
          if (loop_block) state_d = LOOP;  // PC parks on the loop-branch fetch
          else            pc_d    = pc_q + 32'd4;
        end
        LOOP: begin
          ld       = 1'b1;
          src_loop = 1'b1;
          if (!loop_block) state_d = FETCH;
        end
        REDIRECT: begin
          bub = 1'b1;
          if (cnt_q == '0) state_d = FETCH;
          else             cnt_d   = cnt_q - 1'b1;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // State, PC and bubble counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign instr_sel = src_loop ? loop_instr : imem_instr;

  ifid_reg #(.NOP_INSTR(NOP_INSTR)) u_ifid (
    .clk       (clk),
    .reset     (reset),
    .load      (ld),
    .bubble    (bub),
    .pc        (pc_q),
    .instr     (instr_sel),
    .from_loop (src_loop),
    .q         (ifid_q)
  );

  assign curr_pc        = pc_q;
  assign ifid_valid     = ifid_q.valid;
  assign ifid_pc        = ifid_q.pc;
  assign ifid_instr     = ifid_q.instr;
  assign ifid_from_loop = ifid_q.from_loop;

endmodule
